// File: rtl/card_pkg.sv
// rtl/card_pkg.sv - shared card types, colours and geometry for the hand renderer
// Contents: suit_e, card_t, state_e, colour constants, geometry defaults,
//           slot_left() helper for slot left-edge arithmetic.
package card_pkg;

  typedef enum logic [1:0] {
    SUIT_SPADE   = 2'd0,
    SUIT_HEART   = 2'd1,
    SUIT_DIAMOND = 2'd2,
    SUIT_CLUB    = 2'd3
  } suit_e;

  typedef struct packed {
    logic [3:0] value;
    suit_e      suit;
    logic       face_up;
  } card_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SLIDE = 1'b1
  } state_e;

  localparam logic [23:0] BLACK    = 24'h000000;
  localparam logic [23:0] WHITE    = 24'hFFFFFF;
  localparam logic [23:0] RED      = 24'hFF0000;
  localparam logic [23:0] BACK_RGB = 24'h2040C0;

  localparam int DEF_MAX_CARDS    = 6;
  localparam int DEF_CARD_WIDTH   = 60;
  localparam int DEF_CARD_HEIGHT  = 84;
  localparam int DEF_CARD_SPACING = 20;
  localparam int DEF_BORDER_WIDTH = 2;
  localparam int DEF_SLIDE_DIST   = 160;
  localparam int DEF_SLIDE_STEP   = 16;

  // Glyph cell placement inside a card (local coordinates).
  localparam int GLYPH_X0 = 8;
  localparam int GLYPH_Y0 = 8;
  localparam int GLYPH_W  = 18;
  localparam int GLYPH_H  = 28;

  // 11-bit left edge: wide enough that base + slots + slide offset never wraps.
  function automatic logic [10:0] slot_left(input logic [9:0] base, input int idx,
                                            input int spacing, input logic [10:0] extra);
    return 11'(base) + 11'(idx * spacing) + extra;
  endfunction

endpackage

// File: rtl/card_glyph.sv
// rtl/card_glyph.sv - combinational segment-bar glyph for a card value
// Ports: value[3:0] card value (1=A..13=K; 0,14,15 blank)
//        sx[10:0], sy[9:0] card-local pixel coordinates
//        glyph_on  pixel lies on a lit bar of the value's glyph
module card_glyph
  import card_pkg::*;
(
  input  logic [3:0]  value,
  input  logic [10:0] sx,
  input  logic [9:0]  sy,
  output logic        glyph_on
);

  // Seven bars on an 18x28 cell, 2 px thick: {a,b,c,d,e,f,g}
  // a top, b upper-right, c lower-right, d bottom, e lower-left, f upper-left, g middle.
  logic [6:0]  seg;
  logic        in_cell;
  logic [10:0] gx;
  logic [9:0]  gy;
  logic        top, mid, bot, lft, rgt, upper, lower;

  always_comb begin
    seg = 7'b0000000;
    case (value)
      4'd1:  seg = 7'b1110111; // A
      4'd2:  seg = 7'b1101101;
      4'd3:  seg = 7'b1111001;
      4'd4:  seg = 7'b0110011;
      4'd5:  seg = 7'b1011011;
      4'd6:  seg = 7'b1011111;
      4'd7:  seg = 7'b1110000;
      4'd8:  seg = 7'b1111111;
      4'd9:  seg = 7'b1111011;
      4'd10: seg = 7'b1111110;
      4'd11: seg = 7'b0111100; // J
      4'd12: seg = 7'b1110011; // Q
      4'd13: seg = 7'b0110111; // K
      default: seg = 7'b0000000;
    endcase
  end

  assign in_cell = (sx >= 11'(GLYPH_X0)) && (sx < 11'(GLYPH_X0 + GLYPH_W)) &&
                   (sy >= 10'(GLYPH_Y0)) && (sy < 10'(GLYPH_Y0 + GLYPH_H));
  assign gx = sx - 11'(GLYPH_X0);
  assign gy = sy - 10'(GLYPH_Y0);

  assign top   = gy < 10'd2;
  assign mid   = (gy == 10'd13) || (gy == 10'd14);
  assign bot   = gy >= 10'd26;
  assign lft   = gx < 11'd2;
  assign rgt   = gx >= 11'd16;
  assign upper = gy <= 10'd14;
  assign lower = gy >= 10'd13;

  assign glyph_on = in_cell && (
      (seg[6] && top) ||
      (seg[5] && rgt && upper) ||
      (seg[4] && rgt && lower) ||
      (seg[3] && bot) ||
      (seg[2] && lft && lower) ||
      (seg[1] && lft && upper) ||
      (seg[0] && mid));

endmodule

// File: rtl/hand_renderer.sv
// rtl/hand_renderer.sv - card hand store with slide-in animation and 2-stage pixel renderer
// Ports: clk, reset (sync, active-high); x/y/pix_valid pixel in; frame_tick;
//        hand_x/hand_y origin; wr_valid/wr_ready/wr_value/wr_suit/wr_face_up write port;
//        clear, flip_all; card_count, busy; r_out/g_out/b_out, out_valid (pix_valid + 2).
// Option: HAND_RENDERER_SUIT_COLOR_EN renders heart/diamond glyphs red.
module hand_renderer
  import card_pkg::*;
#(
  parameter int MAX_CARDS    = DEF_MAX_CARDS,
  parameter int CARD_WIDTH   = DEF_CARD_WIDTH,
  parameter int CARD_HEIGHT  = DEF_CARD_HEIGHT,
  parameter int CARD_SPACING = DEF_CARD_SPACING,
  parameter int BORDER_WIDTH = DEF_BORDER_WIDTH,
  parameter int SLIDE_DIST   = DEF_SLIDE_DIST,
  parameter int SLIDE_STEP   = DEF_SLIDE_STEP
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [9:0]                     x,
  input  logic [8:0]                     y,
  input  logic                           pix_valid,
  input  logic                           frame_tick,
  input  logic [9:0]                     hand_x,
  input  logic [8:0]                     hand_y,
  input  logic                           wr_valid,
  output logic                           wr_ready,
  input  logic [3:0]                     wr_value,
  input  logic [1:0]                     wr_suit,
  input  logic                           wr_face_up,
  input  logic                           clear,
  input  logic                           flip_all,
  output logic [$clog2(MAX_CARDS+1)-1:0] card_count,
  output logic                           busy,
  output logic [7:0]                     r_out,
  output logic [7:0]                     g_out,
  output logic [7:0]                     b_out,
  output logic                           out_valid
);

  localparam int CNT_W = $clog2(MAX_CARDS + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_CARDS);
  localparam logic [10:0] CW11   = 11'(CARD_WIDTH);
  localparam logic [9:0]  CH10   = 10'(CARD_HEIGHT);
  localparam logic [10:0] BW11   = 11'(BORDER_WIDTH);
  localparam logic [9:0]  BW10   = 10'(BORDER_WIDTH);
  localparam logic [10:0] DIST11 = 11'(SLIDE_DIST);
  localparam logic [10:0] STEP11 = 11'(SLIDE_STEP);

  // ---------------- hand state / FSM ----------------
  state_e           state, state_nxt;
  logic [10:0]      offset, offset_nxt;
  logic [CNT_W-1:0] count_nxt;
  card_t            slots [MAX_CARDS];
  logic             accept;

  assign wr_ready = (state == ST_IDLE) && (card_count < MAX_CNT) && !clear;
  assign accept   = wr_valid && wr_ready;
  assign busy     = (state == ST_SLIDE);

  always_comb begin
    state_nxt  = state;
    offset_nxt = offset;
    count_nxt  = card_count;
    if (clear) begin
      state_nxt  = ST_IDLE;
      offset_nxt = '0;
      count_nxt  = '0;
    end else if (accept) begin
      state_nxt  = ST_SLIDE;
      offset_nxt = DIST11;
      count_nxt  = card_count + 1'b1;
    end else if ((state == ST_SLIDE) && frame_tick) begin
      offset_nxt = (offset > STEP11) ? (offset - STEP11) : '0;
      if (offset_nxt == '0) state_nxt = ST_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      offset     <= '0;
      card_count <= '0;
      for (int i = 0; i < MAX_CARDS; i++) slots[i] <= '0;
    end else begin
      state      <= state_nxt;
      offset     <= offset_nxt;
      card_count <= count_nxt;
      if (flip_all)
        for (int i = 0; i < MAX_CARDS; i++) slots[i].face_up <= 1'b1;
      // accept is never true alongside clear, since wr_ready already masks it
      if (accept)
        slots[card_count] <= '{value: wr_value, suit: suit_e'(wr_suit),
                               face_up: wr_face_up | flip_all};
    end
  end

  // ---------------- stage 1: hit mask ----------------
  // Only the newest card (index card_count-1) carries the slide offset.
  logic [MAX_CARDS-1:0] hit;
  logic [10:0]          slide_off;
  logic [CNT_W-1:0]     top_idx;
  logic [10:0]          left1 [MAX_CARDS];

  assign slide_off = busy ? offset : '0;
  assign top_idx   = card_count - 1'b1;

  always_comb begin
    hit = '0;
    for (int i = 0; i < MAX_CARDS; i++) begin
      left1[i] = slot_left(hand_x, i, CARD_SPACING,
                           (CNT_W'(i) == top_idx) ? slide_off : 11'd0);
      hit[i] = (CNT_W'(i) < card_count) &&
               ({1'b0, x} >= left1[i]) && ({1'b0, x} < left1[i] + CW11) &&
               ({1'b0, y} >= {1'b0, hand_y}) && ({1'b0, y} < {1'b0, hand_y} + CH10);
    end
  end

  // Geometry used by the hit test is snapshotted so stage 2 derives local
  // coordinates from the same edges even if offset/hand_x change next cycle.
  logic [9:0]           s1_x, s1_hand_x;
  logic [8:0]           s1_y, s1_hand_y;
  logic                 s1_valid;
  logic [MAX_CARDS-1:0] s1_hit;
  logic [10:0]          s1_off;
  logic [CNT_W-1:0]     s1_top;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_x      <= '0;
      s1_y      <= '0;
      s1_hand_x <= '0;
      s1_hand_y <= '0;
      s1_valid  <= 1'b0;
      s1_hit    <= '0;
      s1_off    <= '0;
      s1_top    <= '0;
    end else begin
      s1_x      <= x;
      s1_y      <= y;
      s1_hand_x <= hand_x;
      s1_hand_y <= hand_y;
      s1_valid  <= pix_valid;
      s1_hit    <= hit;
      s1_off    <= slide_off;
      s1_top    <= top_idx;
    end
  end

  // ---------------- stage 2: topmost card, colour ----------------
  logic [CNT_W-1:0] sel;
  logic             any_hit;
  logic [10:0]      left2, sx;
  logic [9:0]       sy;
  logic [3:0]       sel_value;
  logic             sel_face;
  logic             in_border;
  logic             glyph_on;
  logic [23:0]      glyph_rgb, rgb_nxt, rgb;

  always_comb begin
    sel = '0;
    for (int i = 0; i < MAX_CARDS; i++)
      if (s1_hit[i]) sel = CNT_W'(i);
  end

  assign any_hit   = |s1_hit;
  assign left2     = slot_left(s1_hand_x, int'(sel), CARD_SPACING,
                               (sel == s1_top) ? s1_off : 11'd0);
  assign sx        = {1'b0, s1_x} - left2;
  assign sy        = {1'b0, s1_y} - {1'b0, s1_hand_y};
  assign sel_value = slots[sel].value;
  assign sel_face  = slots[sel].face_up;
  assign in_border = (sx < BW11) || (sx >= CW11 - BW11) ||
                     (sy < BW10) || (sy >= CH10 - BW10);

  card_glyph u_glyph (
    .value    (sel_value),
    .sx       (sx),
    .sy       (sy),
    .glyph_on (glyph_on)
  );

`ifdef HAND_RENDERER_SUIT_COLOR_EN
  suit_e sel_suit;
  assign sel_suit  = slots[sel].suit;
  assign glyph_rgb = ((sel_suit == SUIT_HEART) || (sel_suit == SUIT_DIAMOND)) ? RED : WHITE;
`else
  assign glyph_rgb = WHITE;
`endif

  always_comb begin
    rgb_nxt = BLACK;
    if (any_hit) begin
      if (in_border)      rgb_nxt = WHITE;
      else if (!sel_face) rgb_nxt = BACK_RGB;
      else if (glyph_on)  rgb_nxt = glyph_rgb;
      else                rgb_nxt = BLACK;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rgb       <= BLACK;
      out_valid <= 1'b0;
    end else begin
      rgb       <= rgb_nxt;
      out_valid <= s1_valid;
    end
  end

  assign r_out = rgb[23:16];
  assign g_out = rgb[15:8];
  assign b_out = rgb[7:0];

endmodule

// File: tb/tb_hand_renderer.sv
// tb/tb_hand_renderer.sv - self-checking bench for hand_renderer
module tb_hand_renderer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [9:0] x = '0;
  logic [8:0] y = '0;
  logic       pix_valid = 1'b0;
  logic       frame_tick = 1'b0;
  logic [9:0] hand_x = '0;
  logic [8:0] hand_y = '0;
  logic       wr_valid = 1'b0;
  logic       wr_ready;
  logic [3:0] wr_value = '0;
  logic [1:0] wr_suit = '0;
  logic       wr_face_up = 1'b0;
  logic       clear = 1'b0;
  logic       flip_all = 1'b0;
  logic [2:0] card_count;
  logic       busy;
  logic [7:0] r_out, g_out, b_out;
  logic       out_valid;

  hand_renderer dut (
    .clk(clk), .reset(reset), .x(x), .y(y), .pix_valid(pix_valid),
    .frame_tick(frame_tick), .hand_x(hand_x), .hand_y(hand_y),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_value(wr_value),
    .wr_suit(wr_suit), .wr_face_up(wr_face_up), .clear(clear),
    .flip_all(flip_all), .card_count(card_count), .busy(busy),
    .r_out(r_out), .g_out(g_out), .b_out(b_out), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  localparam logic [23:0] C_BLACK = 24'h000000;
  localparam logic [23:0] C_WHITE = 24'hFFFFFF;
  localparam logic [23:0] C_BACK  = 24'h2040C0;
`ifdef HAND_RENDERER_SUIT_COLOR_EN
  localparam logic [23:0] C_REDG  = 24'hFF0000;
`else
  localparam logic [23:0] C_REDG  = 24'hFFFFFF;
`endif

  int vectors = 0;
  int miscompares = 0;

  // Behavioural hand model
  int m_val [6];
  int m_suit [6];
  bit m_face [6];
  int m_count = 0;
  bit m_slide = 0;
  int m_off = 0;
  int m_hx = 0;
  int m_hy = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Glyph: bar letters per value on an 18x28 cell, bars 2 px thick.
  function automatic bit glyph_model(int v, int gx, int gy);
    string segs;
    bit on;
    on = 0;
    if (gx < 0 || gx > 17 || gy < 0 || gy > 27) return 0;
    case (v)
      1: segs = "abcefg";  2: segs = "abdeg";   3: segs = "abcdg";
      4: segs = "bcfg";    5: segs = "acdfg";   6: segs = "acdefg";
      7: segs = "abc";     8: segs = "abcdefg"; 9: segs = "abcdfg";
      10: segs = "abcdef"; 11: segs = "bcde";   12: segs = "abcfg";
      13: segs = "bcefg";
      default: segs = "";
    endcase
    for (int k = 0; k < segs.len(); k++) begin
      case (segs[k])
        "a": if (gy < 2) on = 1;
        "b": if (gx >= 16 && gy <= 14) on = 1;
        "c": if (gx >= 16 && gy >= 13) on = 1;
        "d": if (gy >= 26) on = 1;
        "e": if (gx < 2 && gy >= 13) on = 1;
        "f": if (gx < 2 && gy <= 14) on = 1;
        "g": if (gy == 13 || gy == 14) on = 1;
        default: ;
      endcase
    end
    return on;
  endfunction

  function automatic logic [23:0] model_rgb(int px, int py);
    for (int i = m_count - 1; i >= 0; i--) begin
      int left, lx, ly;
      left = m_hx + i * 20 + ((m_slide && i == m_count - 1) ? m_off : 0);
      lx = px - left;
      ly = py - m_hy;
      if (lx >= 0 && lx < 60 && ly >= 0 && ly < 84) begin
        if (lx < 2 || lx >= 58 || ly < 2 || ly >= 82) return C_WHITE;
        if (!m_face[i]) return C_BACK;
        if (glyph_model(m_val[i], lx - 8, ly - 8))
          return (m_suit[i] == 1 || m_suit[i] == 2) ? C_REDG : C_WHITE;
        return C_BLACK;
      end
    end
    return C_BLACK;
  endfunction

  // One clock of control stimulus; model advances at the same edge.
  task automatic drive(input bit wv, input int v, input int s, input bit f,
                       input bit flp, input bit clr, input bit tck);
    bit exp_ready;
    wr_valid = wv; wr_value = v[3:0]; wr_suit = s[1:0]; wr_face_up = f;
    flip_all = flp; clear = clr; frame_tick = tck;
    #1;
    exp_ready = !m_slide && (m_count < 6) && !clr;
    chk("wr_ready", {31'd0, wr_ready}, {31'd0, exp_ready});
    @(posedge clk);
    if (clr) begin
      m_count = 0; m_slide = 0; m_off = 0;
    end else begin
      if (flp) for (int i = 0; i < m_count; i++) m_face[i] = 1;
      if (wv && exp_ready) begin
        m_val[m_count] = v; m_suit[m_count] = s; m_face[m_count] = f | flp;
        m_count++; m_off = 160; m_slide = 1;
      end else if (m_slide && tck) begin
        m_off = (m_off > 16) ? m_off - 16 : 0;
        if (m_off == 0) m_slide = 0;
      end
    end
    #1;
    wr_valid = 0; flip_all = 0; clear = 0; frame_tick = 0;
  endtask

  task automatic write_card(input int v, input int s, input bit f);
    drive(1, v, s, f, 0, 0, 0);
  endtask

  task automatic tick();
    drive(0, 0, 0, 0, 0, 0, 1);
  endtask

  task automatic finish_slide();
    for (int n = 0; n < 12 && m_slide; n++) tick();
  endtask

  task automatic chk_status();
    chk("card_count", {29'd0, card_count}, 32'(m_count));
    chk("busy", {31'd0, busy}, {31'd0, m_slide});
  endtask

  task automatic chk_pix(input int px, input int py);
    logic [23:0] e;
    e = model_rgb(px, py);
    x = px[9:0]; y = py[8:0]; pix_valid = 1;
    @(posedge clk); #1;
    pix_valid = 0;
    @(posedge clk); #1;
    chk($sformatf("rgb(%0d,%0d)", px, py), {8'd0, r_out, g_out, b_out}, {8'd0, e});
    chk("out_valid", {31'd0, out_valid}, 32'd1);
  endtask

  task automatic set_hand(input int hx, input int hy);
    m_hx = hx; m_hy = hy;
    hand_x = hx[9:0]; hand_y = hy[8:0];
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n, px, py;
    // Reset
    reset = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_rgb", {8'd0, r_out, g_out, b_out}, 32'd0);
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    reset = 0;
    #1;
    chk_status();

    // Basic deal + slide position
    set_hand(100, 300);
    write_card(1, 0, 1);
    chk_status();
    chk_pix(260, 310);
    chk_pix(100, 310);
    repeat (5) tick();
    chk_pix(180, 310);
    chk_pix(179, 310);
    repeat (4) tick();
    chk_status();
    tick();
    chk_status();
    chk_pix(100, 300);
    chk_pix(140, 350);
    chk_pix(112, 308);

    // pix_valid low: out_valid low
    x = 10'd100; y = 9'd300; pix_valid = 0;
    @(posedge clk); @(posedge clk); #1;
    chk("out_valid_low", {31'd0, out_valid}, 32'd0);

    // Overlap of two face-down cards
    drive(0, 0, 0, 0, 0, 1, 0);
    write_card(7, 3, 0); finish_slide();
    write_card(9, 0, 0); finish_slide();
    chk_pix(120, 310);
    chk_pix(110, 310);

    // Flip and suit colour
    drive(0, 0, 0, 0, 0, 1, 0);
    write_card(5, 1, 0); finish_slide();
    chk_pix(112, 308);
    drive(0, 0, 0, 0, 1, 0, 0);
    chk_pix(112, 308);
    chk_pix(116, 318);

    // Write with flip_all: dealt face-up
    drive(1, 2, 2, 0, 1, 0, 0);
    finish_slide();
    chk_pix(132, 308);

    // Full hand
    drive(0, 0, 0, 0, 0, 1, 0);
    for (int k = 0; k < 6; k++) begin
      write_card($urandom_range(1, 13), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      finish_slide();
    end
    drive(1, 4, 0, 1, 0, 0, 0);
    chk_status();
    for (int k = 0; k < 8; k++) chk_pix($urandom_range(95, 220), $urandom_range(295, 390));

    // Clear mid-slide with a concurrent write
    drive(0, 0, 0, 0, 0, 1, 0);
    write_card(3, 1, 1);
    repeat (3) tick();
    drive(1, 6, 0, 1, 0, 1, 0);
    chk_status();
    chk_pix(212, 310);
    chk_pix(100, 310);

    // Randomised hands, including mid-slide snapshots
    for (int r = 0; r < 4; r++) begin
      drive(0, 0, 0, 0, 0, 1, 0);
      set_hand($urandom_range(0, 500), $urandom_range(0, 380));
      n = $urandom_range(1, 6);
      for (int k = 0; k < n; k++) begin
        write_card($urandom_range(0, 15), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        if (k == n - 1) repeat ($urandom_range(0, 10)) tick();
        else finish_slide();
      end
      if (r == 2) drive(0, 0, 0, 0, 1, 0, 0);
      chk_status();
      for (int k = 0; k < 12; k++) begin
        px = $urandom_range(m_hx + 300, (m_hx > 10) ? m_hx - 10 : 0);
        py = $urandom_range(m_hy + 100, (m_hy > 10) ? m_hy - 10 : 0);
        chk_pix(px, py);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/hand_renderer.md
Name: hand_renderer

Overview:
- Sequential successor to the single-card drawer.
- Holds a hand of up to MAX_CARDS cards, loaded through a valid/ready write port, and renders the hand as overlapping cards at a configurable origin.
- Newly dealt cards slide in from the right, stepped by frame ticks. Cards may be face-down and flipped later.
- Sits between the Blackjack game FSM (card source) and the VGA colour mux; output is pipelined by 2 clocks against the pixel coordinate.

Parameters:
- MAX_CARDS, 6: card slot count.
- CARD_WIDTH, 60: card width in px.
- CARD_HEIGHT, 84: card height in px.
- CARD_SPACING, 20: x pitch between slots. Smaller than CARD_WIDTH, so cards overlap.
- BORDER_WIDTH, 2: border thickness in px.
- SLIDE_DIST, 160: initial x offset of a newly dealt card.
- SLIDE_STEP, 16: offset decrement per frame_tick.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- x  in  10  pixel column (0..639)
- y  in  9  pixel row (0..479)
- pix_valid  in  1  x/y are valid this cycle
- frame_tick  in  1  one-cycle pulse per video frame
- hand_x  in  10  slot-0 left edge
- hand_y  in  9  hand top edge
- wr_valid  in  1  card write request
- wr_ready  out  1  write can be accepted
- wr_value  in  4  1=A, 2..10, 11=J, 12=Q, 13=K
- wr_suit  in  2  0=spade, 1=heart, 2=diamond, 3=club
- wr_face_up  in  1  card dealt face-up
- clear  in  1  empty the hand
- flip_all  in  1  set every held card face-up
- card_count  out  $clog2(MAX_CARDS+1)  cards held
- busy  out  1  slide animation in progress
- r_out, g_out, b_out  out  8 each  pixel colour
- out_valid  out  1  pix_valid delayed by 2

Behaviour:
- Reset: card_count=0; all slots zeroed; state IDLE; busy=0; rgb=0; out_valid=0; pipeline flushed.
- FSM has two states, IDLE and SLIDE.
- wr_ready = (state==IDLE) && (card_count<MAX_CARDS) && !clear.
- Accepting a write (wr_valid && wr_ready):
  - slot[card_count] <= {value, suit, face_up | flip_all}.
  - card_count increments.
  - offset <= SLIDE_DIST; state -> SLIDE.
- In SLIDE, each frame_tick sets offset <= max(offset-SLIDE_STEP, 0). When the new offset is 0, state -> IDLE on the same edge. busy = (state==SLIDE).
- Slot i left edge = hand_x + i*CARD_SPACING, plus offset for slot card_count-1 while in SLIDE. Computed at 11 bits with no wrap; off-screen parts are simply never hit.
- clear, synchronous, beats everything else:
  - card_count <= 0; state <= IDLE; offset <= 0.
  - A concurrent write is dropped, since wr_ready is already 0.
- flip_all sets face_up on all held slots.
- flip_all together with a write: the written card is also face-up.
- Pixel pipeline. Latency is exactly 2 clocks and is independent of FSM state, clear, and frame_tick.
  - Stage 1: register x, y, pix_valid. Compute the hit mask over slots 0..card_count-1.
  - Stage 2: select the highest-index hit slot (the topmost card) and compute its local coordinates. Register the colour.
- Colour rules:
  - No hit: 000000.
  - Hit, in border: FFFFFF.
  - Face-down interior: BACK_RGB = 2040C0.
  - Face-up interior, glyph pixel (local sx 8..25, sy 8..35, glyph on): FFFFFF.
  - Face-up interior, other pixels: 000000.
- Values 0, 14, 15 render border plus blank body.
- Glyph shapes use segment-bar shapes: bars are 2 px thick, on an 18x28 cell.
- When pix_valid=0, the colour still computes, but out_valid=0.

Optional Feature:
- Macro: HAND_RENDERER_SUIT_COLOR_EN.
- When defined, face-up glyph pixels for hearts and diamonds (suit 1 and 2) are FF0000; spades and clubs stay FFFFFF.
- When undefined, suit is stored but ignored and all glyphs are FFFFFF.

Decomposition:
- Package card_pkg holds:
  - card_t struct {value[3:0], suit_e suit, face_up}
  - suit_e enum
  - colour constants: BLACK, WHITE, RED, BACK_RGB
  - geometry defaults
- Sub-module card_glyph: combinational. Inputs are value and local sx/sy; output is glyph_on. It is instantiated once in stage 2.

Test Plan:
- Basic deal:
  - Stimulus: reset; hand_x=100, hand_y=300; write A face-up; 10 frame_ticks.
  - Response: busy falls on the 10th tick. Pixel (100,300) gives FFFFFF two clocks later; pixel (140,350) gives 000000.
- Slide position:
  - Stimulus: write a card into slot 0.
  - Response: before any tick, pixel (260,310) is border FFFFFF and (100,310) is black. After 5 ticks, the left edge is at 180.
- Overlap:
  - Stimulus: two face-down cards at x=100 and 120.
  - Response: pixel (120,310) is border FFFFFF from card 1; pixel (110,310) is BACK_RGB from card 0.
- Full hand:
  - Stimulus: write 6 cards, finishing each slide, then assert wr_valid a 7th time.
  - Response: wr_ready=0; card_count stays 6.
- Clear mid-slide:
  - Stimulus: assert clear 3 ticks after a write.
  - Response: next cycle busy=0, card_count=0, and all pixels are 000000. A write in the same cycle is ignored.
- Flip and suit colour:
  - Stimulus: write face-down heart 5, then pulse flip_all.
  - Response: glyph pixels change from BACK_RGB to FF0000 with the macro defined, or to FFFFFF without it.
